// File: rtl/moonbase_cpu_nibble_gen2.sv
// moonbase_cpu_nibble_gen2: parametrised nibble-serial accumulator CPU.
// One nibble per cycle moves over the external SRAM / device bus.
module moonbase_cpu_nibble_gen2 #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int STACK_DEPTH = 4,
    parameter int N_LOCAL_RAM = 8,
    localparam int NN  = DATA_W / 4,
    localparam int NSW = (NN > 1) ? $clog2(NN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        ram_in,
    input  logic [1:0]        dev_in,
    output logic              strobe,
    output logic [ADDR_W-1:0] addr_out,
    output logic              code_sel,
    output logic [NSW-1:0]    nib_sel,
    output logic [3:0]        data_out,
    output logic              wr_ram_n,
    output logic              wr_dev_n,
    output logic              halted,
    output logic              stk_err
);
    localparam int LW  = $clog2(N_LOCAL_RAM);
    localparam int SPW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {FA, INS, VF, OA, OD, EX, WR, HLT} phase_t;

    phase_t            ph;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] a, b, x, y, opnd;
    logic              c;
    logic [3:0]        op, v;
    logic [NSW-1:0]    k;
    logic [SPW-1:0]    sp;
    logic [ADDR_W-1:0] stk [STACK_DEPTH];
    logic [DATA_W-1:0] lram [N_LOCAL_RAM];

    logic [3:0]        vv;
    logic [ADDR_W-1:0] ea;
    logic              loc, is_st, skip, last, full, empty;
    logic              wr_r, wr_d, cond;
    logic [DATA_W-1:0] m;
    logic [DATA_W:0]   sum, dif;
    logic [DATA_W-1:0] a_n, b_n, x_n, y_n;
    logic              c_n, push, pop;
    logic [ADDR_W-1:0] pc_n;

    // v is still on ram_in during VF, so the operand address is formed early
    always_comb begin
        vv    = (ph == VF) ? ram_in : v;
        ea    = (vv[3] ? y[ADDR_W-1:0] : x[ADDR_W-1:0]) + ADDR_W'(vv[2:0]);
        loc   = vv[3] ? y[DATA_W-1] : x[DATA_W-1];
        is_st = (op == 4'hA) || (op == 4'hB);
        skip  = (op >= 4'h7) && (op <= 4'hE);
        last  = (k == NSW'((op == 4'h6) ? 0 : NN - 1));
        full  = (sp == SPW'(STACK_DEPTH));
        empty = (sp == '0);
        wr_r  = (op == 4'hB) && !loc;
        wr_d  = (op == 4'hA);
        m     = (loc && op <= 4'h5) ? lram[ea[LW-1:0]] : opnd;
        sum   = {1'b0, a} + {1'b0, m};
        dif   = {1'b0, a} - {1'b0, m};
        cond  = opnd[DATA_W-1] ? c : (a == '0);
    end

    always_comb begin
        a_n  = a;
        b_n  = b;
        x_n  = x;
        y_n  = y;
        c_n  = c;
        pc_n = pc;
        push = 1'b0;
        pop  = 1'b0;
        case (op)
            4'h0: {c_n, a_n} = sum;
            4'h1: {c_n, a_n} = dif;
            4'h2: a_n = a | m;
            4'h3: a_n = a & m;
            4'h4: a_n = a ^ m;
            4'h5, 4'h6: a_n = m;
            4'h7: case (v)
                4'h0: begin x_n = y; y_n = x; end
                4'h1: a_n = a + DATA_W'(c);
                4'h3: begin pop = 1'b1; pc_n = empty ? '0 : stk[0]; end
                4'h4: y_n = y + a;
                4'h5: x_n = x + a;
                4'h6: y_n = y + DATA_W'(1);
                4'h7: x_n = x + DATA_W'(1);
                default: ;
            endcase
            4'h8: case (v)
                4'h0: a_n = y;
                4'h1: a_n = x;
                4'h2: b_n = a;
                4'h3: begin a_n = b; b_n = a; end
                4'h4: y_n = a;
                4'h5: x_n = a;
                4'h7: a_n = DATA_W'(pc);
                default: ;
            endcase
            4'hF: case (v)
                4'h0: a_n = opnd;
                4'h1: {c_n, a_n} = sum;
                4'h2: x_n = opnd;
                4'h3: y_n = opnd;
                4'h4: if (!cond) pc_n = opnd[ADDR_W-1:0];
                4'h5: if (cond) pc_n = opnd[ADDR_W-1:0];
                4'h6: begin pc_n = opnd[ADDR_W-1:0]; push = opnd[DATA_W-1]; end
                default: ;
            endcase
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph       <= FA;
            pc       <= '0;
            a        <= '0;
            b        <= '0;
            x        <= '0;
            y        <= '0;
            c        <= 1'b0;
            opnd     <= '0;
            op       <= '0;
            v        <= '0;
            k        <= '0;
            sp       <= '0;
            strobe   <= 1'b1;
            addr_out <= '0;
            code_sel <= 1'b1;
            nib_sel  <= '0;
            data_out <= '0;
            wr_ram_n <= 1'b1;
            wr_dev_n <= 1'b1;
            halted   <= 1'b0;
            stk_err  <= 1'b0;
        end else begin
            strobe   <= 1'b0;
            wr_ram_n <= 1'b1;
            wr_dev_n <= 1'b1;
            case (ph)
                FA: begin
                    ph      <= INS;
                    nib_sel <= '0;
                end
                INS: begin
                    op      <= ram_in;
                    ph      <= VF;
                    nib_sel <= NSW'(1);
                end
                VF: begin
                    v       <= ram_in;
                    pc      <= pc + ADDR_W'(1);
                    k       <= '0;
                    nib_sel <= '0;
                    if (skip) begin
                        ph <= EX;
                        if (is_st) begin
                            strobe   <= 1'b1;
                            code_sel <= 1'b0;
                            addr_out <= ea;
                        end
                    end else begin
                        ph       <= OA;
                        strobe   <= 1'b1;
                        code_sel <= (op == 4'hF);
                        addr_out <= (op == 4'hF) ? pc + ADDR_W'(1) : ea;
                    end
                end
                OA: begin
                    ph      <= OD;
                    nib_sel <= '0;
                end
                OD: begin
                    if (op == 4'h6) opnd <= DATA_W'(dev_in);
                    else opnd[4*k +: 4] <= ram_in;
                    if (last) begin
                        ph <= EX;
                        if (op == 4'hF) pc <= pc + ADDR_W'(1);
                    end else begin
                        k       <= k + NSW'(1);
                        nib_sel <= k + NSW'(1);
                    end
                end
                EX: begin
                    a  <= a_n;
                    b  <= b_n;
                    x  <= x_n;
                    y  <= y_n;
                    c  <= c_n;
                    pc <= pc_n;
                    if (push) begin
                        for (int i = STACK_DEPTH - 1; i > 0; i--) stk[i] <= stk[i-1];
                        stk[0] <= pc;
                        if (full) stk_err <= 1'b1;
                        else sp <= sp + SPW'(1);
                    end
                    if (pop) begin
                        if (empty) stk_err <= 1'b1;
                        else begin
                            for (int i = 0; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
                            sp <= sp - SPW'(1);
                        end
                    end
                    if (is_st) begin
                        if (op == 4'hB && loc) lram[ea[LW-1:0]] <= a;
                        ph       <= WR;
                        k        <= '0;
                        nib_sel  <= '0;
                        data_out <= a[3:0];
                        wr_ram_n <= !wr_r;
                        wr_dev_n <= !wr_d;
                    end else if (op == 4'h7 && v == 4'h8) begin
                        ph     <= HLT;
                        halted <= 1'b1;
                    end else begin
                        ph       <= FA;
                        strobe   <= 1'b1;
                        code_sel <= 1'b1;
                        addr_out <= pc_n;
                        nib_sel  <= '0;
                    end
                end
                WR: begin
                    if (k == NSW'(NN - 1)) begin
                        ph       <= FA;
                        strobe   <= 1'b1;
                        code_sel <= 1'b1;
                        addr_out <= pc;
                        nib_sel  <= '0;
                    end else begin
                        k        <= k + NSW'(1);
                        nib_sel  <= k + NSW'(1);
                        data_out <= a[4*(int'(k)+1) +: 4];
                        wr_ram_n <= !wr_r;
                        wr_dev_n <= !wr_d;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_moonbase_cpu_nibble_gen2.sv
// Bench for moonbase_cpu_nibble_gen2: 8-bit and 16-bit cores against
// nibble SRAM models and an instruction-level reference model.
module tb_moonbase_cpu_nibble_gen2;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       reset8 = 1'b1, reset16 = 1'b1;
    logic [3:0] ram8, ram16;
    logic [1:0] dev8 = '0, dev16 = '0;
    logic       strobe8, code_sel8, nib8, wr_ram_n8, wr_dev_n8, halted8, stk_err8;
    logic       strobe16, code_sel16, wr_ram_n16, wr_dev_n16, halted16, stk_err16;
    logic [6:0] addr8, addr16;
    logic [1:0] nib16;
    logic [3:0] dout8, dout16;

    logic [7:0]  code8 [128];
    logic [7:0]  data8 [128];
    logic [15:0] code16 [128];
    logic [15:0] data16 [128];
    logic [6:0]  lat8 = '0, lat16 = '0;
    logic        cs8 = 1'b1, cs16 = 1'b1;
    int          wr8_cnt = 0;

    moonbase_cpu_nibble_gen2 u8 (
        .clk(clk), .reset(reset8), .ram_in(ram8), .dev_in(dev8),
        .strobe(strobe8), .addr_out(addr8), .code_sel(code_sel8),
        .nib_sel(nib8), .data_out(dout8), .wr_ram_n(wr_ram_n8),
        .wr_dev_n(wr_dev_n8), .halted(halted8), .stk_err(stk_err8));

    moonbase_cpu_nibble_gen2 #(.DATA_W(16)) u16 (
        .clk(clk), .reset(reset16), .ram_in(ram16), .dev_in(dev16),
        .strobe(strobe16), .addr_out(addr16), .code_sel(code_sel16),
        .nib_sel(nib16), .data_out(dout16), .wr_ram_n(wr_ram_n16),
        .wr_dev_n(wr_dev_n16), .halted(halted16), .stk_err(stk_err16));

    always_comb begin
        ram8  = cs8 ? code8[lat8][4*nib8 +: 4] : data8[lat8][4*nib8 +: 4];
        ram16 = cs16 ? code16[lat16][4*nib16 +: 4] : data16[lat16][4*nib16 +: 4];
    end

    // external latch and SRAM writes are serviced mid-cycle
    task automatic tick();
        @(negedge clk);
        if (strobe8) begin lat8 = addr8; cs8 = code_sel8; end
        if (!wr_ram_n8) begin
            data8[lat8][4*nib8 +: 4] = dout8;
            wr8_cnt++;
        end
        if (strobe16) begin lat16 = addr16; cs16 = code_sel16; end
        if (!wr_ram_n16) data16[lat16][4*nib16 +: 4] = dout16;
        @(posedge clk);
        #1;
    endtask

    task automatic clear8();
        for (int i = 0; i < 128; i++) begin
            code8[i] = 8'h87;
            data8[i] = 8'h00;
        end
    endtask

    task automatic put8(inout int p, input logic [7:0] w);
        code8[p] = w;
        p++;
    endtask

    task automatic do_reset8();
        reset8 = 1'b1;
        tick();
        tick();
        reset8 = 1'b0;
    endtask

    task automatic run_halt8(input string nm, input int bound, output int cyc);
        cyc = 0;
        while (!halted8 && cyc < bound) begin
            tick();
            cyc++;
        end
        checks++;
        if (halted8 !== 1'b1) begin
            errors++;
            $display("FAIL %s halt: halted=%0b after %0d cycles, need 1", nm, halted8, cyc);
        end
    endtask

    task automatic test_reset();
        clear8();
        do_reset8();
        checks++;
        if ({strobe8, addr8, code_sel8, nib8, wr_ram_n8, wr_dev_n8, halted8, stk_err8}
            !== {1'b1, 7'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: stb=%0b addr=%0d cs=%0b nib=%0b wr=%0b%0b h=%0b se=%0b",
                     strobe8, addr8, code_sel8, nib8, wr_ram_n8, wr_dev_n8, halted8, stk_err8);
        end
    endtask

    task automatic test_imm_add();
        int p = 0, cyc;
        clear8();
        put8(p, 8'h0F); put8(p, 8'h3C); put8(p, 8'h1F); put8(p, 8'hD5);
        put8(p, 8'h7B); put8(p, 8'h0F); put8(p, 8'h00); put8(p, 8'h17);
        put8(p, 8'h6B); put8(p, 8'h87);
        do_reset8();
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (!(strobe8 === 1'b1 && addr8 === 7'd4 && code_sel8 === 1'b1)) begin
            errors++;
            $display("FAIL imm_timing: stb=%0b addr=%0d at cycle 14, need 1/4", strobe8, addr8);
        end
        run_halt8("imm_add", 100, cyc);
        checks++;
        if (data8[7] !== 8'h11) begin
            errors++;
            $display("FAIL imm_add_a: got %h need 11", data8[7]);
        end
        checks++;
        if (data8[6] !== 8'h01) begin
            errors++;
            $display("FAIL imm_add_c: got %h need 01", data8[6]);
        end
    endtask

    task automatic test_local_ram();
        int p = 0, cyc, w0;
        clear8();
        data8[1] = 8'h3C;
        put8(p, 8'h2F); put8(p, 8'h80); put8(p, 8'h0F); put8(p, 8'hA5);
        put8(p, 8'h1B); put8(p, 8'h0F); put8(p, 8'h00); put8(p, 8'h15);
        put8(p, 8'h2F); put8(p, 8'h00); put8(p, 8'h7B); put8(p, 8'h87);
        do_reset8();
        w0 = wr8_cnt;
        run_halt8("local", 200, cyc);
        checks++;
        if (data8[7] !== 8'hA5) begin
            errors++;
            $display("FAIL local_readback: got %h need A5", data8[7]);
        end
        checks++;
        if (data8[1] !== 8'h3C || wr8_cnt - w0 != 2) begin
            errors++;
            $display("FAIL local_no_ext_write: ext[1]=%h wr_cycles=%0d need 3C/2",
                     data8[1], wr8_cnt - w0);
        end
    endtask

    task automatic test_addr_wrap();
        int p = 0, cyc;
        clear8();
        put8(p, 8'h2F); put8(p, 8'h7F); put8(p, 8'h0F); put8(p, 8'h5A);
        put8(p, 8'h1B); put8(p, 8'h87);
        do_reset8();
        run_halt8("wrap", 100, cyc);
        checks++;
        if (data8[0] !== 8'h5A) begin
            errors++;
            $display("FAIL addr_wrap: data[0]=%h need 5A", data8[0]);
        end
    endtask

    task automatic test_call_stack();
        int exp_tr [17] = '{0, 1, 4, 5, 8, 9, 12, 13, 16, 17, 20, 18, 14, 10, 6, 0, 1};
        int tr [17];
        int n = 0, cyc = 0;
        logic e16 = 1'b1, e20 = 1'b0;
        clear8();
        for (int i = 0; i < 5; i++) begin
            code8[4*i]   = 8'h6F;
            code8[4*i+1] = 8'h80 | 8'(4*i + 4);
        end
        code8[20] = 8'h37; code8[18] = 8'h37; code8[14] = 8'h37;
        code8[10] = 8'h37; code8[6]  = 8'h37;
        do_reset8();
        while (n < 17 && cyc < 400) begin
            if (strobe8 && code_sel8) begin
                tr[n] = int'(addr8);
                if (addr8 == 7'd16) e16 = stk_err8;
                if (addr8 == 7'd20) e20 = stk_err8;
                n++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL stack_trace_len: got %0d fetches need 17", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (tr[i] != exp_tr[i]) begin
                errors++;
                $display("FAIL stack_fetch[%0d]: addr %0d need %0d", i, tr[i], exp_tr[i]);
            end
        end
        checks++;
        if (e16 !== 1'b0 || e20 !== 1'b1) begin
            errors++;
            $display("FAIL stack_err: before 5th call %0b after %0b need 0/1", e16, e20);
        end
        do_reset8();
        checks++;
        if (stk_err8 !== 1'b0) begin
            errors++;
            $display("FAIL stack_err_reset: got %0b need 0", stk_err8);
        end
    endtask

    task automatic test_reset_mid_op();
        int p = 0, cyc;
        clear8();
        put8(p, 8'h0F); put8(p, 8'h3C); put8(p, 8'h0F); put8(p, 8'h55);
        do_reset8();
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (strobe8 !== 1'b0 || nib8 !== 1'b1) begin
            errors++;
            $display("FAIL mid_pos: stb=%0b nib=%0b need 0/1", strobe8, nib8);
        end
        reset8 = 1'b1;
        tick();
        checks++;
        if (!(strobe8 === 1'b1 && addr8 === 7'd0 && halted8 === 1'b0 && code_sel8 === 1'b1)) begin
            errors++;
            $display("FAIL mid_reset: stb=%0b addr=%0d h=%0b need 1/0/0", strobe8, addr8, halted8);
        end
        clear8();
        data8[7] = 8'hEE;
        code8[0] = 8'h7B;
        code8[1] = 8'h87;
        tick();
        reset8 = 1'b0;
        run_halt8("mid_reset", 60, cyc);
        checks++;
        if (data8[7] !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_a: got %h need 00", data8[7]);
        end
    endtask

    task automatic test_halt();
        int p = 0, cyc, viol = 0;
        clear8();
        put8(p, 8'h0F); put8(p, 8'h00); put8(p, 8'h5F); put8(p, 8'h90);
        put8(p, 8'h87);
        code8[16] = 8'h00;
        do_reset8();
        run_halt8("halt", 60, cyc);
        checks++;
        if (cyc != 18) begin
            errors++;
            $display("FAIL halt_cycles: %0d need 18", cyc);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!halted8 || strobe8 || !wr_ram_n8 || !wr_dev_n8) viol++;
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL halt_hold: %0d bad cycles need 0", viol);
        end
        do_reset8();
        checks++;
        if (halted8 !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: halted=%0b need 0", halted8);
        end
    endtask

    task automatic test_wide16();
        logic [3:0] exp_d [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        logic [3:0] wd [8];
        logic [1:0] wn [8];
        int n = 0, cyc = 0;
        for (int i = 0; i < 128; i++) begin
            code16[i] = 16'h0087;
            data16[i] = 16'h0000;
        end
        code16[0] = 16'h000F; code16[1] = 16'h1234;
        code16[2] = 16'h000B; code16[3] = 16'h0087;
        reset16 = 1'b1;
        tick();
        tick();
        reset16 = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (!(strobe16 === 1'b1 && addr16 === 7'd2)) begin
            errors++;
            $display("FAIL w16_timing: stb=%0b addr=%0d need 1/2", strobe16, addr16);
        end
        while (!halted16 && cyc < 60) begin
            if (!wr_ram_n16 && n < 8) begin
                wd[n] = dout16;
                wn[n] = nib16;
                n++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (n != 4 || !halted16) begin
            errors++;
            $display("FAIL w16_pulses: %0d pulses halted=%0b need 4/1", n, halted16);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++;
            if (wd[i] !== exp_d[i] || wn[i] !== 2'(i)) begin
                errors++;
                $display("FAIL w16_nib[%0d]: nib=%0d data=%h need %0d/%h", i, wn[i], wd[i], i, exp_d[i]);
            end
        end
        checks++;
        if (data16[0] !== 16'h1234) begin
            errors++;
            $display("FAIL w16_mem: got %h need 1234", data16[0]);
        end
    endtask

    // reference: one ALU-class op applied to A and the operand value
    task automatic test_random_alu();
        for (int it = 0; it < 40; it++) begin
            int sel, p, cyc, r;
            logic [7:0] a0, m0, mm, ra;
            logic [2:0] vi;
            logic [1:0] dv;
            logic rc;
            sel = $urandom_range(0, 7);
            a0  = 8'($urandom);
            m0  = 8'($urandom);
            vi  = 3'($urandom_range(0, 5));
            dv  = 2'($urandom);
            clear8();
            for (int i = 0; i < 128; i++) data8[i] = 8'($urandom);
            data8[vi] = m0;
            dev8 = dv;
            p = 0;
            put8(p, 8'h0F); put8(p, a0);
            if (sel == 7) begin put8(p, 8'h1F); put8(p, m0); end
            else put8(p, {1'b0, vi, 4'(sel)});
            put8(p, 8'h7B); put8(p, 8'h0F); put8(p, 8'h00);
            put8(p, 8'h17); put8(p, 8'h6B); put8(p, 8'h87);
            mm = (sel == 6) ? {6'b0, dv} : m0;
            rc = 1'b0;
            case (sel)
                0, 7: begin r = int'(a0) + int'(mm); ra = 8'(r); rc = r > 255; end
                1: begin ra = 8'(int'(a0) - int'(mm)); rc = a0 < mm; end
                2: ra = a0 | mm;
                3: ra = a0 & mm;
                4: ra = a0 ^ mm;
                default: ra = mm;
            endcase
            do_reset8();
            run_halt8("rand", 100, cyc);
            checks++;
            if (data8[7] !== ra) begin
                errors++;
                $display("FAIL rand_a[%0d] op%0d a=%h m=%h: got %h need %h", it, sel, a0, mm, data8[7], ra);
            end
            checks++;
            if (data8[6] !== {7'b0, rc}) begin
                errors++;
                $display("FAIL rand_c[%0d] op%0d a=%h m=%h: got %h need %0b", it, sel, a0, mm, data8[6], rc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_imm_add();
        test_local_ram();
        test_addr_wrap();
        test_call_stack();
        test_reset_mid_op();
        test_halt();
        test_wide16();
        test_random_alu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
